serial_word_collector: RTL and testbench

//   Serial-in/parallel-out stage that sits downstream of the 4-bit bidirectional

---
 rtl/serial_pkg.sv | 5 +
 rtl/serial_word_collector_sipo_core.sv | 46 ++++
 rtl/serial_word_collector.sv | 88 ++++++++
 tb/tb_serial_word_collector.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types for the serial collector and the upstream shift-register bench.
package serial_pkg;
  typedef enum logic {DIR_LSB_FIRST = 1'b0, DIR_MSB_FIRST = 1'b1} dir_t;
  typedef enum logic {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} col_state_t;
endpackage

// File: rtl/serial_word_collector_sipo_core.sv
// Shift register, bit counter and per-word direction latch for the serial collector.
module serial_word_collector_sipo_core
  import serial_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             msb_first,
  output logic [WIDTH-1:0] next_word,
  output logic             word_done,
  output logic [CNT_W-1:0] bit_cnt
);

  logic [WIDTH-1:0] sh;
  dir_t             dir_q;
  dir_t             dir_eff;
  logic             first_bit;

  // The first bit of a word uses the live direction input; the rest use the latch.
  assign first_bit = (bit_cnt == '0);
  assign dir_eff   = first_bit ? dir_t'(msb_first) : dir_q;
  assign next_word = (dir_eff == DIR_MSB_FIRST) ? {sh[WIDTH-2:0], bit_in}
                                                : {bit_in, sh[WIDTH-1:1]};
  assign word_done = bit_vld && !clr && (bit_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh      <= '0;
      bit_cnt <= '0;
      dir_q   <= DIR_LSB_FIRST;
    end else if (clr) begin
      sh      <= '0;
      bit_cnt <= '0;
    end else if (bit_vld) begin
      sh      <= next_word;
      bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
      if (first_bit) dir_q <= dir_t'(msb_first);
    end
  end

endmodule

// File: rtl/serial_word_collector.sv
// Serial-to-parallel word collector with a one-entry valid/ready holding register
// and a sticky overrun flag for completed words that had nowhere to go.
module serial_word_collector
  import serial_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_vld,
  input  logic             msb_first,
  input  logic             clr,
  output logic [WIDTH-1:0] word_out,
  output logic             word_vld,
  input  logic             word_rdy,
  output logic             busy,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             overrun
);

  logic [WIDTH-1:0] next_word;
  logic             word_done;
  col_state_t       state;
  logic             hold_free;

  serial_word_collector_sipo_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_core (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .msb_first (msb_first),
    .next_word (next_word),
    .word_done (word_done),
    .bit_cnt   (bit_cnt)
  );

  // Holding register can take a new word if empty or being drained this cycle.
  assign hold_free = !word_vld || word_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      word_out <= '0;
      word_vld <= 1'b0;
      overrun  <= 1'b0;
    end else if (clr) begin
      state    <= ST_IDLE;
      busy     <= 1'b0;
      word_vld <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bit_vld) begin
            state <= ST_COLLECT;
            busy  <= 1'b1;
          end
        end
        ST_COLLECT: begin
          if (word_done) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (word_done) begin
        if (hold_free) begin
          word_out <= next_word;
          word_vld <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (word_vld && word_rdy) begin
        word_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed bench for serial_word_collector (WIDTH=4) with a handshake scoreboard.
module tb_serial_word_collector;
  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bit_in = 1'b0;
  logic             bit_vld = 1'b0;
  logic             msb_first = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] word_out;
  logic             word_vld;
  logic             word_rdy = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] bit_cnt;
  logic             overrun;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  serial_word_collector #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_in    (bit_in),
    .bit_vld   (bit_vld),
    .msb_first (msb_first),
    .clr       (clr),
    .word_out  (word_out),
    .word_vld  (word_vld),
    .word_rdy  (word_rdy),
    .busy      (busy),
    .bit_cnt   (bit_cnt),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one bit for exactly one accepting edge; returns 1 time unit after that edge.
  task automatic send(input logic b, input logic m);
    bit_in    = b;
    msb_first = m;
    bit_vld   = 1'b1;
    @(posedge clk);
    #1;
    bit_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted handshake must match the oldest expected word.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !clr && word_vld && word_rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h expected none", word_out);
        end else begin
          check("handshake_word", word_out, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [3:0] pat;
    // Reset state
    idle(2);
    check("rst_word_vld", word_vld, 0);
    check("rst_word_out", word_out, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_bit_cnt", bit_cnt, 0);
    rst = 1'b0;
    idle(1);

    // 1: MSB-first 1,0,1,1 -> 4'hB, valid for exactly one cycle
    word_rdy = 1'b1;
    send(1, 1); send(0, 1); send(1, 1); send(1, 1);
    exp_q.push_back(4'hB);
    check("t1_vld_rise", word_vld, 1);
    check("t1_word", word_out, 4'hB);
    idle(1);
    check("t1_vld_fall", word_vld, 0);

    // 2: LSB-first 1,0,1,1 -> 4'hD, msb_first toggled after the first bit
    send(1, 0); send(0, 1); send(1, 1); send(1, 1);
    exp_q.push_back(4'hD);
    check("t2_word", word_out, 4'hD);
    idle(2);

    // 3: stalled holding register -> overrun
    word_rdy = 1'b0;
    send(1, 1); send(1, 1); send(1, 1); send(1, 1);
    exp_q.push_back(4'hF);
    send(0, 1); send(0, 1); send(0, 1); send(0, 1);
    check("t3_word_kept", word_out, 4'hF);
    check("t3_overrun", overrun, 1);
    check("t3_vld_held", word_vld, 1);
    word_rdy = 1'b1;
    idle(1);
    check("t3_drained", word_vld, 0);
    check("t3_overrun_sticky", overrun, 1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("t3_clr_overrun", overrun, 0);

    // 4: second completion coincides with the drain of the first word
    word_rdy = 1'b0;
    send(1, 1); send(0, 1); send(1, 1); send(0, 1);
    exp_q.push_back(4'hA);
    check("t4_first", word_out, 4'hA);
    send(0, 1); check("t4_vld_b5", word_vld, 1);
    send(1, 1); check("t4_vld_b6", word_vld, 1);
    send(1, 1); check("t4_vld_b7", word_vld, 1);
    word_rdy = 1'b1;
    send(0, 1);
    exp_q.push_back(4'h6);
    check("t4_vld_b8", word_vld, 1);
    check("t4_second", word_out, 4'h6);
    check("t4_overrun", overrun, 0);
    idle(2);

    // 5a: async reset mid-word
    send(1, 1); send(1, 1);
    check("t5_cnt_before", bit_cnt, 2);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    check("t5_rst_cnt", bit_cnt, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_vld", word_vld, 0);
    check("t5_rst_overrun", overrun, 0);
    idle(1);
    send(0, 1); send(1, 1); send(0, 1); send(1, 1);
    exp_q.push_back(4'h5);
    check("t5_word", word_out, 4'h5);
    idle(2);

    // 5b: clr mid-word, with the clr-cycle bit discarded
    send(1, 1); send(1, 1);
    clr = 1'b1;
    send(1, 1);
    clr = 1'b0;
    check("t5_clr_cnt", bit_cnt, 0);
    check("t5_clr_busy", busy, 0);
    send(0, 1); send(1, 1); send(0, 1); send(1, 1);
    exp_q.push_back(4'h5);
    check("t5_clr_word", word_out, 4'h5);
    idle(2);

    // 6: random gaps; MSB 1,1,0,0 -> 4'hC then LSB 1,1,1,0 -> 4'h7
    for (int w = 0; w < 2; w++) begin
      pat = (w == 0) ? 4'b1100 : 4'b1110;
      for (int i = 0; i < 4; i++) begin
        idle($urandom_range(0, 3));
        check("t6_bit_cnt", bit_cnt, i);
        check("t6_busy", busy, (i != 0));
        send(pat[3-i], (w == 0));
      end
      exp_q.push_back((w == 0) ? 4'hC : 4'h7);
      check("t6_word", word_out, (w == 0) ? 4'hC : 4'h7);
      check("t6_cnt_wrap", bit_cnt, 0);
    end
    idle(3);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
